// File: rtl/assert_monitor.sv
// assert_monitor
//   Watches a vector of per-channel test conditions during an armed window
//   and records sticky failure status.
//   Inside the window every enabled channel must read 1; any enabled channel
//   at 0 is a failure.
//
//   Optional feature: define ASSERT_MONITOR_TIMEOUT_EN to build the busy
//   watchdog. While the block is ARMED, the watchdog declares a timeout once
//   `busy` has been high for TIMEOUT_CYC consecutive cycles. Without the macro
//   there is no watchdog, `timeout` is tied to 0 and `busy` is ignored.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   arm       level: high opens and holds the monitoring window
//   clr       pulse: clears all status and returns to IDLE (beats arm)
//   test      per-channel condition, must be 1 while ARMED
//   mask      per-channel enable (1 = checked)
//   busy      watched busy flag for the watchdog
//   state     IDLE=00 ARMED=01 PASS=10 FAIL=11
//   fail      sticky: any channel failure or timeout seen
//   fail_ch   sticky per-channel failure flags
//   first_ch  lowest failing index of the first failing sample
//   fail_cnt  saturating count of sampled cycles with any failure
//   timeout   sticky watchdog expiry flag
module assert_monitor #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 10000,
  localparam int FCH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                clr,
  input  logic [CHANNELS-1:0] test,
  input  logic [CHANNELS-1:0] mask,
  input  logic                busy,
  output logic [1:0]          state,
  output logic                fail,
  output logic [CHANNELS-1:0] fail_ch,
  output logic [FCH_W-1:0]    first_ch,
  output logic [CNT_W-1:0]    fail_cnt,
  output logic                timeout
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ARMED = 2'b01;
  localparam logic [1:0] ST_PASS  = 2'b10;
  localparam logic [1:0] ST_FAIL  = 2'b11;

  logic [CHANNELS-1:0] err;
  logic                err_any;
  logic [FCH_W-1:0]    err_low;
  logic                wd_hit;
  logic                leaving;

  assign err     = mask & ~test;
  assign err_any = |err;
  assign leaving = (state == ST_ARMED) && !arm;

  // Lowest set index of err: scan from the top so the last hit wins.
  always_comb begin
    err_low = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (err[i]) begin
        err_low = FCH_W'(i);
      end
    end
  end

`ifdef ASSERT_MONITOR_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  logic [WD_W-1:0] wd_cnt;
  logic [WD_W-1:0] wd_next;

  // Consecutive busy cycles while ARMED; the count holds at the limit so it
  // can never wrap back below it during a long busy stretch.
  always_comb begin
    wd_next = '0;
    if (state == ST_ARMED && busy) begin
      wd_next = (wd_cnt == WD_W'(TIMEOUT_CYC)) ? wd_cnt : wd_cnt + WD_W'(1);
    end
  end

  assign wd_hit = (state == ST_ARMED) && (wd_next == WD_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else if (clr) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      // The exit edge still counts toward a timeout, but the count restarts
      // once the window is left.
      wd_cnt <= leaving ? '0 : wd_next;
      if (wd_hit) begin
        timeout <= 1'b1;
      end
    end
  end
`else
  logic busy_unused;

  assign busy_unused = busy;
  assign wd_hit      = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      fail     <= 1'b0;
      fail_ch  <= '0;
      first_ch <= '0;
      fail_cnt <= '0;
    end else if (clr) begin
      state    <= ST_IDLE;
      fail     <= 1'b0;
      fail_ch  <= '0;
      first_ch <= '0;
      fail_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) begin
            state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (err_any) begin
            fail_ch <= fail_ch | err;
            // Only the very first failing sample sets first_ch.
            if (fail_ch == '0) begin
              first_ch <= err_low;
            end
            if (fail_cnt != '1) begin
              fail_cnt <= fail_cnt + CNT_W'(1);
            end
          end
          if (err_any || wd_hit) begin
            fail <= 1'b1;
          end
          // The exit edge has already sampled, so its result decides PASS/FAIL.
          if (!arm) begin
            state <= (fail || err_any || wd_hit) ? ST_FAIL : ST_PASS;
          end
        end
        default: begin
          // PASS and FAIL hold everything until clr.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_assert_monitor.sv
// tb_assert_monitor
//   Two monitors share one stimulus stream: dut_a with default parameters and
//   dut_b with CNT_W=3, TIMEOUT_CYC=5. A behavioural model per instance is
//   stepped at each clock edge and compared against the outputs on every
//   falling edge; directed scenarios add hand-computed literal expectations.
module tb_assert_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arm = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] test = 4'hF;
  logic [3:0] mask = 4'h0;
  logic       busy = 1'b0;

  logic [1:0]  a_state, b_state;
  logic        a_fail, b_fail;
  logic [3:0]  a_fch, b_fch;
  logic [1:0]  a_first, b_first;
  logic [15:0] a_cnt;
  logic [2:0]  b_cnt;
  logic        a_tmo, b_tmo;

  int checks = 0;
  int errors = 0;
  bit started = 0;

`ifdef ASSERT_MONITOR_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  assert_monitor #(.CHANNELS(4)) dut_a (
    .clk(clk), .rst(rst), .arm(arm), .clr(clr), .test(test), .mask(mask),
    .busy(busy), .state(a_state), .fail(a_fail), .fail_ch(a_fch),
    .first_ch(a_first), .fail_cnt(a_cnt), .timeout(a_tmo)
  );

  assert_monitor #(.CHANNELS(4), .CNT_W(3), .TIMEOUT_CYC(5)) dut_b (
    .clk(clk), .rst(rst), .arm(arm), .clr(clr), .test(test), .mask(mask),
    .busy(busy), .state(b_state), .fail(b_fail), .fail_ch(b_fch),
    .first_ch(b_first), .fail_cnt(b_cnt), .timeout(b_tmo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  st;
    logic        fail;
    logic        tmo;
    logic [3:0]  fch;
    logic [1:0]  first;
    logic [31:0] cnt;
    logic [31:0] wd;
  } mdl_t;

  mdl_t m_a = '0;
  mdl_t m_b = '0;

  function automatic logic [1:0] lowest(input logic [3:0] v);
    logic [1:0] r;
    bit found;
    r = 2'd0;
    found = 0;
    for (int i = 0; i < 4; i++) begin
      if (v[i] && !found) begin
        r = 2'(i);
        found = 1;
      end
    end
    return r;
  endfunction

  // One clock edge of the monitor, from the behavioural rules.
  function automatic mdl_t step(input mdl_t m, input logic a, input logic c,
                                input logic [3:0] t, input logic [3:0] mk,
                                input logic b, input int cmax, input int tlim);
    mdl_t n;
    logic [3:0] e;
    n = m;
    e = mk & ~t;
    if (c) begin
      n = '0;
      return n;
    end
    if (m.st == 2'd0) begin
      if (a) n.st = 2'd1;
    end else if (m.st == 2'd1) begin
      if (e != 4'd0) begin
        if (m.fch == 4'd0) n.first = lowest(e);
        n.fch = m.fch | e;
        n.fail = 1'b1;
        if (m.cnt < 32'(cmax)) n.cnt = m.cnt + 1;
      end
      if (WD_EN) begin
        n.wd = b ? m.wd + 1 : 0;
        if (n.wd >= 32'(tlim)) begin
          n.wd = 32'(tlim);
          n.tmo = 1'b1;
          n.fail = 1'b1;
        end
      end
      if (!a) begin
        n.st = n.fail ? 2'd3 : 2'd2;
        n.wd = 0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a <= '0;
      m_b <= '0;
    end else begin
      m_a <= step(m_a, arm, clr, test, mask, busy, 65535, 10000);
      m_b <= step(m_b, arm, clr, test, mask, busy, 7, 5);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model comparison on every falling edge.
  always @(negedge clk) begin
    if (started) begin
      chk("a.state", 32'(a_state), 32'(m_a.st));
      chk("a.fail", 32'(a_fail), 32'(m_a.fail));
      chk("a.fail_ch", 32'(a_fch), 32'(m_a.fch));
      chk("a.fail_cnt", 32'(a_cnt), m_a.cnt);
      chk("a.timeout", 32'(a_tmo), 32'(m_a.tmo));
      if (m_a.fch != 4'd0) chk("a.first_ch", 32'(a_first), 32'(m_a.first));
      chk("b.state", 32'(b_state), 32'(m_b.st));
      chk("b.fail", 32'(b_fail), 32'(m_b.fail));
      chk("b.fail_ch", 32'(b_fch), 32'(m_b.fch));
      chk("b.fail_cnt", 32'(b_cnt), m_b.cnt);
      chk("b.timeout", 32'(b_tmo), 32'(m_b.tmo));
      if (m_b.fch != 4'd0) chk("b.first_ch", 32'(b_first), 32'(m_b.first));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    arm = 1'b0;
    tick(1);
    clr = 1'b0;
  endtask

  initial begin
    tick(2);
    started = 1;
    chk("reset.state", 32'(a_state), 0);
    chk("reset.fail", 32'(a_fail), 0);
    chk("reset.cnt", 32'(a_cnt), 0);
    chk("reset.fch", 32'(b_fch), 0);
    chk("reset.tmo", 32'(b_tmo), 0);
    rst = 1'b0;
    tick(1);

    // All channels good for 50 armed cycles.
    mask = 4'hF; test = 4'hF; arm = 1'b1;
    tick(1);
    chk("pass.armed", 32'(a_state), 1);
    tick(50);
    arm = 1'b0;
    tick(1);
    chk("pass.state", 32'(a_state), 2);
    chk("pass.fail", 32'(a_fail), 0);
    chk("pass.cnt", 32'(a_cnt), 0);
    do_clr();

    // Channel 2 fails 3 cycles, then channel 3 fails 1 cycle.
    arm = 1'b1;
    tick(1);
    test = 4'b1011;
    tick(3);
    test = 4'b0111;
    tick(1);
    test = 4'hF; arm = 1'b0;
    tick(1);
    chk("f2.fail_ch", 32'(a_fch), 32'hC);
    chk("f2.first_ch", 32'(a_first), 2);
    chk("f2.cnt", 32'(a_cnt), 4);
    chk("f2.cnt_b", 32'(b_cnt), 4);
    chk("f2.state", 32'(a_state), 3);
    do_clr();

    // Everything masked: pass even with test low; PASS then ignores input.
    mask = 4'h0; test = 4'h0; arm = 1'b1;
    tick(6);
    arm = 1'b0;
    tick(1);
    chk("mask.state", 32'(a_state), 2);
    chk("mask.fail", 32'(a_fail), 0);
    mask = 4'b0001; arm = 1'b1;
    tick(2);
    chk("hold.state", 32'(a_state), 2);
    chk("hold.fch", 32'(a_fch), 0);
    do_clr();
    mask = 4'h0; arm = 1'b1;
    tick(2);
    mask = 4'b0001;
    tick(1);
    mask = 4'h0;
    tick(1);
    arm = 1'b0;
    tick(1);
    chk("mask1.fch", 32'(a_fch), 1);
    chk("mask1.cnt", 32'(a_cnt), 1);
    chk("mask1.state", 32'(a_state), 3);
    do_clr();

    // Watchdog: busy held high while armed.
    mask = 4'hF; test = 4'hF; busy = 1'b1; arm = 1'b1;
    tick(1);
    tick(4);
    chk("wd.before", 32'(b_tmo), 0);
    tick(1);
`ifdef ASSERT_MONITOR_TIMEOUT_EN
    chk("wd.timeout", 32'(b_tmo), 1);
    chk("wd.fail", 32'(b_fail), 1);
`else
    chk("wd.timeout_off", 32'(b_tmo), 0);
    chk("wd.fail_off", 32'(b_fail), 0);
`endif
    chk("wd.fch", 32'(b_fch), 0);
    chk("wd.armed", 32'(b_state), 1);
    tick(2);
    arm = 1'b0; busy = 1'b0;
    tick(1);
    chk("wd.a_pass", 32'(a_state), 2);
    do_clr();

    // Counter saturation on the 3-bit instance.
    mask = 4'hF; test = 4'h0; arm = 1'b1;
    tick(1);
    tick(10);
    chk("sat.b", 32'(b_cnt), 7);
    chk("sat.a", 32'(a_cnt), 10);
    arm = 1'b0;
    tick(1);
    chk("sat.hold", 32'(b_cnt), 7);
    chk("sat.first", 32'(b_first), 0);
    do_clr();

    // Asynchronous reset mid-window with fail set.
    test = 4'b1110; arm = 1'b1;
    tick(3);
    chk("rst.pre_fail", 32'(a_fail), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst.state", 32'(a_state), 0);
    chk("rst.fail", 32'(a_fail), 0);
    chk("rst.fch", 32'(a_fch), 0);
    chk("rst.cnt", 32'(b_cnt), 0);
    #2 rst = 1'b0;
    test = 4'hF;
    tick(1);
    chk("rst.resume", 32'(a_state), 1);
    arm = 1'b0;
    tick(1);
    chk("rst.pass", 32'(a_state), 2);

    // clr together with arm in PASS goes to IDLE, not ARMED.
    clr = 1'b1; arm = 1'b1;
    tick(1);
    chk("clr.state", 32'(a_state), 0);
    chk("clr.fail", 32'(a_fail), 0);
    clr = 1'b0; arm = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/assert_monitor.md
ASSERT_MONITOR -- requirements
Module: assert_monitor

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent test inputs monitored, range 1..32.
REQ-002 Parameter CNT_W, default 16: width of the failure-cycle counter.
REQ-003 Parameter TIMEOUT_CYC, default 10000: consecutive busy cycles allowed while ARMED before a timeout is declared; must be at least 1.
REQ-004 Derived width FCH_W SHALL be $clog2(CHANNELS), with a minimum of 1.
REQ-005 clk  input  1  rising-edge system clock; all registers clocked by it.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 arm  input  1  level; high requests and holds a monitoring window.
REQ-008 clr  input  1  single-cycle pulse; clears all status and returns to IDLE.
REQ-009 test  input  CHANNELS  per-channel condition; must be 1 while ARMED.
REQ-010 mask  input  CHANNELS  per-channel enable; 1 = channel checked.
REQ-011 busy  input  1  watched busy flag for the timeout watchdog.
REQ-012 state  output  2  IDLE=00, ARMED=01, PASS=10, FAIL=11.
REQ-013 fail  output  1  sticky: any failure or timeout recorded.
REQ-014 fail_ch  output  CHANNELS  sticky per-channel failure flags.
REQ-015 first_ch  output  FCH_W  index of the first failing channel; meaningful only when fail_ch is non-zero.
REQ-016 fail_cnt  output  CNT_W  count of cycles with at least one failing enabled channel.
REQ-017 timeout  output  1  sticky watchdog expiry flag.

Function
REQ-018 All outputs SHALL be registered; status reflects a sample one cycle after the sampling edge.
REQ-019 IDLE: arm=1 at an edge SHALL move to ARMED; no sampling is done in IDLE.
REQ-020 ARMED: each edge SHALL sample the vector err = mask & ~test.
REQ-021 Any err bit set SHALL set fail and OR err into fail_ch.
REQ-022 The increment of fail_cnt SHALL be one per sampled cycle with err non-zero, regardless of how many bits are set.
REQ-023 The fail_cnt counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 On the first cycle where fail_ch transitions from zero to non-zero, first_ch SHALL capture the lowest set index of err.
REQ-025 Once captured, first_ch SHALL hold until clr or reset.
REQ-026 ARMED with arm=0 at an edge: that edge still samples; next state SHALL be FAIL if fail (including this sample) else PASS.
REQ-027 PASS/FAIL: outputs SHALL hold; arm is ignored until clr.
REQ-028 clr=1 in any state SHALL, at the next edge, force IDLE and zero fail, fail_ch, first_ch, fail_cnt, timeout, and the watchdog count; clr has priority over arm and sampling.
REQ-029 The watchdog counter SHALL count consecutive ARMED cycles with busy=1 and reset to 0 on busy=0 or on leaving ARMED.
REQ-030 When the watchdog count reaches TIMEOUT_CYC, timeout and fail SHALL be set; the watchdog does not modify fail_ch, first_ch or fail_cnt.
REQ-031 After a timeout the block SHALL stay ARMED until arm falls, then enter FAIL.
REQ-032 A mask change SHALL take effect on the same edge; fail_ch bits already set are never cleared by mask.

Reset
REQ-033 rst=1 SHALL asynchronously force state=IDLE and all status outputs and internal counters to 0.
REQ-034 rst mid-window SHALL discard all recorded status; operation resumes in IDLE after rst deasserts.

Configuration
REQ-035 With ASSERT_MONITOR_TIMEOUT_EN defined, the watchdog per REQ-029..REQ-031 SHALL be present.
REQ-036 Without ASSERT_MONITOR_TIMEOUT_EN, no watchdog logic SHALL exist; timeout is constant 0 and busy is unused.

Verification
REQ-037 CHANNELS=4, mask=1111, test=1111 for 50 armed cycles, arm falls -> state=PASS, fail=0, fail_cnt=0.
REQ-038 CHANNELS=4, test=1011 for 3 armed cycles, then test=0111 for 1 cycle -> fail_ch=1100, first_ch=2, fail_cnt=4, FAIL after arm falls.
REQ-039 test=0000 with mask=0000 for the whole window -> PASS; then mask=0001 for 1 cycle -> fail_ch=0001, fail_cnt=1.
REQ-040 TIMEOUT_CYC=5, macro defined, busy held 1 while armed -> timeout=1 and fail=1 in the cycle after the 5th busy cycle, fail_ch=0; without macro -> timeout stays 0.
REQ-041 CNT_W=3, err non-zero for 10 armed cycles -> fail_cnt=7 held.
REQ-042 rst pulsed mid-window with fail=1 -> all outputs 0 immediately, state=IDLE; clr asserted together with arm in PASS -> IDLE with status zeroed, not ARMED.
